cycle_counter_bank: RTL and testbench



---
 rtl/cycle_counter_bank_pkg.sv | 23 ++
 rtl/cycle_counter_channel.sv | 78 +++++++
 rtl/cycle_counter_bank.sv | 39 +++
 tb/tb_cycle_counter_bank.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cycle_counter_bank_pkg
// Description : Shared sizing defaults for the cycle counter bank and the
//               downstream PWM pipeline, plus the per-channel action encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cycle_counter_bank_pkg;

  // Cycle/count bit width and transducer channel count shared with PWM stages
  localparam int unsigned CCB_WIDTH = 13;
  localparam int unsigned CCB_DEPTH = 249;

  // What a channel does on the coming edge, in priority order after reset
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_WRAP  = 2'd2,
    ACT_SYNC  = 2'd3
  } ccb_action_e;

endpackage : cycle_counter_bank_pkg
`default_nettype wire

// File: rtl/cycle_counter_channel.sv
`default_nettype none
// ============================================================================
// Module      : cycle_counter_channel
// Description : Single transducer period counter. Holds the running count,
//               a shadow copy of the requested period-minus-one that is only
//               reloaded at wrap or SYNC, and a registered last-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_counter_channel
  import cycle_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = CCB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [WIDTH-1:0] i_cycle_m1,
  output logic [WIDTH-1:0] o_time_cnt,
  output logic             o_last
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  ccb_action_e      act;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_m1_q, active_m1_d;
  logic             last_q, last_d;

  // Pick the action and derive next-state; last is computed from next-state so
  // it lines up with the count it describes.
  always_comb begin
    act         = ACT_HOLD;
    cnt_d       = cnt_q;
    active_m1_d = active_m1_q;
    last_d      = last_q;

    if (i_sync) begin
      act = ACT_SYNC;
    end else if (i_en) begin
      act = (cnt_q == active_m1_q) ? ACT_WRAP : ACT_COUNT;
    end

    unique case (act)
      ACT_SYNC, ACT_WRAP: begin
        cnt_d       = '0;
        active_m1_d = i_cycle_m1;
        last_d      = (i_cycle_m1 == '0);
      end
      ACT_COUNT: begin
        cnt_d  = cnt_q + C_ONE;
        last_d = (cnt_d == active_m1_q);
      end
      default: begin
        // Hold: everything, including last, keeps its value
        last_d = last_q;
      end
    endcase
  end

  // Channel state registers; reset also takes a fresh period snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      last_q      <= 1'b0;
      active_m1_q <= i_cycle_m1;
    end else begin
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      active_m1_q <= active_m1_d;
    end
  end

  assign o_time_cnt = cnt_q;
  assign o_last     = last_q;

endmodule : cycle_counter_channel
`default_nettype wire

// File: rtl/cycle_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : cycle_counter_bank
// Description : Bank of independent per-transducer period counters sharing
//               enable, sync and reset. Outputs are straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_counter_bank
  import cycle_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = CCB_WIDTH,
  parameter int unsigned DEPTH = CCB_DEPTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             SYNC,
  input  logic [WIDTH-1:0] CYCLE_M1 [DEPTH],
  output logic [WIDTH-1:0] TIME_CNT [DEPTH],
  output logic             LAST     [DEPTH]
);

  // One counter per channel, all sharing the common controls
  for (genvar g = 0; g < DEPTH; g++) begin : g_channel
    cycle_counter_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk        (CLK),
      .rst_n      (RST_N),
      .i_en       (EN),
      .i_sync     (SYNC),
      .i_cycle_m1 (CYCLE_M1[g]),
      .o_time_cnt (TIME_CNT[g]),
      .o_last     (LAST[g])
    );
  end : g_channel

endmodule : cycle_counter_bank
`default_nettype wire

// File: tb/tb_cycle_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_counter_bank
// Description : Directed self-checking bench for cycle_counter_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_counter_bank;

  localparam int unsigned W = 13;
  localparam int unsigned D = 4;

  logic         CLK;
  logic         RST_N;
  logic         EN;
  logic         SYNC;
  logic [W-1:0] CYCLE_M1 [D];
  logic [W-1:0] TIME_CNT [D];
  logic         LAST     [D];

  int pass_cnt  = 0;
  int check_cnt = 0;

  cycle_counter_bank #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EN       (EN),
    .SYNC     (SYNC),
    .CYCLE_M1 (CYCLE_M1),
    .TIME_CNT (TIME_CNT),
    .LAST     (LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge; inputs set before the call are sampled at that edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) CYCLE_M1[i] = v;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; EN = 1'b0; SYNC = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    set_all(13'd3);
    do_reset();
    for (int i = 0; i < D; i++) begin
      check_cnt++;
      if (TIME_CNT[i] !== 13'd0 || LAST[i] !== 1'b0)
        $display("FAIL reset ch%0d: cnt=%0d last=%b, want cnt=0 last=0", i, TIME_CNT[i], LAST[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic_count();
    logic [W-1:0] exp_c [8];
    logic         exp_l [8];
    exp_c = '{13'd1, 13'd2, 13'd3, 13'd0, 13'd1, 13'd2, 13'd3, 13'd0};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    set_all(13'd3);
    do_reset();
    EN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== exp_c[k] || LAST[0] !== exp_l[k])
        $display("FAIL basic_count step%0d: cnt=%0d last=%b, want cnt=%0d last=%b",
                 k, TIME_CNT[0], LAST[0], exp_c[k], exp_l[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_cycle_change();
    logic [W-1:0] exp_c [9];
    logic         exp_l [9];
    exp_c = '{13'd2, 13'd3, 13'd0, 13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd0};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    set_all(13'd3);
    do_reset();
    EN = 1'b1;
    step();                 // count 1
    CYCLE_M1[0] = 13'd5;
    for (int k = 0; k < 9; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== exp_c[k] || LAST[0] !== exp_l[k])
        $display("FAIL cycle_change step%0d: cnt=%0d last=%b, want cnt=%0d last=%b",
                 k, TIME_CNT[0], LAST[0], exp_c[k], exp_l[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sync();
    CYCLE_M1[0] = 13'd4; CYCLE_M1[1] = 13'd6;
    CYCLE_M1[2] = 13'd2; CYCLE_M1[3] = 13'd9;
    do_reset();
    EN = 1'b1;
    for (int k = 0; k < 10; k++) step();
    // Drift before sync: ch0 at 10 mod 5, ch1 at 10 mod 7
    check_cnt++;
    if (TIME_CNT[0] !== 13'd0 || TIME_CNT[1] !== 13'd3)
      $display("FAIL sync_predrift: ch0=%0d ch1=%0d, want ch0=0 ch1=3", TIME_CNT[0], TIME_CNT[1]);
    else pass_cnt++;
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    for (int i = 0; i < D; i++) begin
      check_cnt++;
      if (TIME_CNT[i] !== 13'd0 || LAST[i] !== 1'b0)
        $display("FAIL sync_zero ch%0d: cnt=%0d last=%b, want cnt=0 last=0", i, TIME_CNT[i], LAST[i]);
      else pass_cnt++;
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== W'(k % 5) || TIME_CNT[1] !== W'(k % 7) ||
          LAST[0] !== (k % 5 == 4) || LAST[1] !== (k % 7 == 6))
        $display("FAIL sync_lockstep step%0d: ch0=%0d/%b ch1=%0d/%b, want ch0=%0d/%b ch1=%0d/%b",
                 k, TIME_CNT[0], LAST[0], TIME_CNT[1], LAST[1],
                 k % 5, (k % 5 == 4), k % 7, (k % 7 == 6));
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_hold();
    set_all(13'd3);
    do_reset();
    EN = 1'b1;
    step(); step();         // count 2
    EN = 1'b0;
    CYCLE_M1[0] = 13'd7;    // must be ignored while held
    for (int k = 0; k < 5; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== 13'd2 || LAST[0] !== 1'b0)
        $display("FAIL en_hold cycle%0d: cnt=%0d last=%b, want cnt=2 last=0", k, TIME_CNT[0], LAST[0]);
      else pass_cnt++;
    end
    EN = 1'b1;
    step();
    check_cnt++;
    if (TIME_CNT[0] !== 13'd3 || LAST[0] !== 1'b1)
      $display("FAIL en_resume: cnt=%0d last=%b, want cnt=3 last=1", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
    // Held with LAST high keeps LAST high
    EN = 1'b0;
    step();
    check_cnt++;
    if (TIME_CNT[0] !== 13'd3 || LAST[0] !== 1'b1)
      $display("FAIL en_hold_last: cnt=%0d last=%b, want cnt=3 last=1", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
    // SYNC while disabled: count 0 then held; reloads the new period 7
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== 13'd0 || LAST[0] !== 1'b0)
        $display("FAIL sync_en0 cycle%0d: cnt=%0d last=%b, want cnt=0 last=0", k, TIME_CNT[0], LAST[0]);
      else pass_cnt++;
    end
    EN = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check_cnt++;
    if (TIME_CNT[0] !== 13'd4 || LAST[0] !== 1'b0)
      $display("FAIL sync_reload: cnt=%0d last=%b, want cnt=4 last=0", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
  endtask

  task automatic test_zero_period();
    set_all(13'd0);
    do_reset();
    check_cnt++;
    if (TIME_CNT[0] !== 13'd0 || LAST[0] !== 1'b0)
      $display("FAIL zero_first: cnt=%0d last=%b, want cnt=0 last=0", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
    EN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== 13'd0 || LAST[0] !== 1'b1)
        $display("FAIL zero_period step%0d: cnt=%0d last=%b, want cnt=0 last=1", k, TIME_CNT[0], LAST[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_full_period();
    bit seq_ok;
    int bad_k;
    set_all(13'h1FFF);
    do_reset();
    EN = 1'b1;
    seq_ok = 1'b1;
    bad_k  = -1;
    for (int k = 1; k <= 8190; k++) begin
      step();
      if (seq_ok && (TIME_CNT[0] !== W'(k) || LAST[0] !== 1'b0)) begin
        seq_ok = 1'b0;
        bad_k  = k;
      end
    end
    check_cnt++;
    if (!seq_ok)
      $display("FAIL full_ramp: first bad step %0d cnt=%0d last=%b, want cnt=%0d last=0",
               bad_k, TIME_CNT[0], LAST[0], bad_k);
    else pass_cnt++;
    step();
    check_cnt++;
    if (TIME_CNT[0] !== 13'd8191 || LAST[0] !== 1'b1)
      $display("FAIL full_top: cnt=%0d last=%b, want cnt=8191 last=1", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
    step();
    check_cnt++;
    if (TIME_CNT[0] !== 13'd0 || LAST[0] !== 1'b0)
      $display("FAIL full_wrap: cnt=%0d last=%b, want cnt=0 last=0", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_c [4];
    logic         exp_l [4];
    exp_c = '{13'd1, 13'd2, 13'd0, 13'd1};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b0};
    set_all(13'd6);
    do_reset();
    EN = 1'b1;
    for (int k = 0; k < 4; k++) step();   // count 4
    check_cnt++;
    if (TIME_CNT[0] !== 13'd4)
      $display("FAIL rst_mid_pre: cnt=%0d, want 4", TIME_CNT[0]);
    else pass_cnt++;
    set_all(13'd2);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check_cnt++;
    if (TIME_CNT[0] !== 13'd0 || LAST[0] !== 1'b0)
      $display("FAIL rst_mid: cnt=%0d last=%b, want cnt=0 last=0", TIME_CNT[0], LAST[0]);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step();
      check_cnt++;
      if (TIME_CNT[0] !== exp_c[k] || LAST[0] !== exp_l[k])
        $display("FAIL rst_mid_run step%0d: cnt=%0d last=%b, want cnt=%0d last=%b",
                 k, TIME_CNT[0], LAST[0], exp_c[k], exp_l[k]);
      else pass_cnt++;
    end
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; SYNC = 1'b0;
    set_all('0);
    test_reset();
    test_basic_count();
    test_cycle_change();
    test_sync();
    test_enable_hold();
    test_zero_period();
    test_full_period();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_cycle_counter_bank
`default_nettype wire
